// File: rtl/polar_serial_encoder_pkg.sv
// Shared types and helpers for the bit-serial polar encoder (package polar_pkg).
// Row steps use the Pascal-mod-2 recurrence. Row i, bit j is set when j is a bit-subset of i.
package polar_pkg;

  localparam int unsigned ROW_MAX = 1024;

  typedef enum logic [1:0] {IDLE, ACC, OUT} enc_state_t;

  function automatic int unsigned N_of(input int unsigned n);
    return 32'd1 << n;
  endfunction

  // One Pascal-XOR step: new[k] = row[k-1] ^ row[k], and new[0] is always 1.
  function automatic logic [ROW_MAX-1:0] row_next(input logic [ROW_MAX-1:0] row);
    return {row[ROW_MAX-2:0] ^ row[ROW_MAX-1:1], 1'b1};
  endfunction

endpackage

// File: rtl/polar_serial_encoder_if.sv
// Message-in / codeword-out handshake bundle for polar_serial_encoder.
interface polar_serial_encoder_if import polar_pkg::*; #(
  parameter int unsigned n = 2
);
  localparam int unsigned N = N_of(n);

  logic         u_valid;
  logic         u_ready;
  logic         u_bit;
  logic         x_valid;
  logic         x_ready;
  logic [N-1:0] x;

  modport master (output u_valid, u_bit, x_ready, input u_ready, x_valid, x);
  modport slave  (input u_valid, u_bit, x_ready, output u_ready, x_valid, x);
endinterface

// File: rtl/polar_serial_encoder_row_gen.sv
// Generates the rows of G_N in order using Pascal mod 2.
// load restarts the sequence at row 0 and takes priority over step.
module polar_row_gen import polar_pkg::*; #(
  parameter int unsigned n = 2,
  localparam int unsigned N = N_of(n)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  output logic [N-1:0] row
);

  logic [ROW_MAX-1:0] wide_next;

  assign wide_next = row_next(ROW_MAX'(row));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      row <= N'(1);
    end else if (step) begin
      row <= wide_next[N-1:0];
    end
  end

  if (N < ROW_MAX) begin : g_sink
    logic row_unused;
    assign row_unused = ^wide_next[ROW_MAX-1:N];
  end

endmodule

// File: rtl/polar_serial_encoder.sv
// Bit-serial polar encoder. It computes x = u * G_N in natural order and returns the codeword in parallel.
// Optional macro POLAR_FROZEN_FORCE_EN forces the bits at FROZEN_MASK positions to 0.
module polar_serial_encoder import polar_pkg::*; #(
  parameter int unsigned n = 2,
  parameter logic [N_of(n)-1:0] FROZEN_MASK = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  polar_serial_encoder_if.slave  bus,
  output logic                   busy
);

  localparam int unsigned N = N_of(n);

  enc_state_t   state;
  logic [n-1:0] idx;
  logic [N-1:0] row;
  logic [N-1:0] acc;
  logic [N-1:0] acc_next;
  logic [N-1:0] x_q;
  logic         u_ready_q;
  logic         x_valid_q;
  logic         eff_bit;
  logic         xfer;
  logic         x_take;
  logic         last;

  assign xfer   = bus.u_valid & u_ready_q;
  assign x_take = x_valid_q & bus.x_ready;
  assign last   = (idx == n'(N - 1));

`ifdef POLAR_FROZEN_FORCE_EN
  assign eff_bit = bus.u_bit & ~FROZEN_MASK[idx];
`else
  logic mask_unused;
  assign mask_unused = ^FROZEN_MASK;
  assign eff_bit     = bus.u_bit;
`endif

  assign acc_next = acc ^ (eff_bit ? row : '0);

  polar_row_gen #(.n(n)) u_row_gen (
    .clk  (clk),
    .rst  (rst),
    .load (x_take),
    .step (xfer),
    .row  (row)
  );

  // In IDLE, acc is 0 and row is 1, so the first bit follows the same path as every later bit.
  // idx holds at N-1 through OUT and wraps only when the codeword is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      x_q       <= '0;
      u_ready_q <= 1'b1;
      x_valid_q <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (xfer) begin
            busy <= 1'b1;
            acc  <= acc_next;
            if (last) begin
              state     <= OUT;
              x_q       <= acc_next;
              u_ready_q <= 1'b0;
              x_valid_q <= 1'b1;
            end else begin
              state <= ACC;
              idx   <= idx + 1'b1;
            end
          end
        end
        OUT: begin
          if (x_take) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            u_ready_q <= 1'b1;
            x_valid_q <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.u_ready = u_ready_q;
  assign bus.x_valid = x_valid_q;
  assign bus.x       = x_q;

endmodule

// File: tb/tb_polar_serial_encoder.sv
// Self-checking bench for polar_serial_encoder: directed n=2 scenarios plus randomized n=3 frames.
`timescale 1ns/1ps
module tb_polar_serial_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  polar_serial_encoder_if #(.n(2)) a();
  polar_serial_encoder_if #(.n(3)) b();
  logic busy_a, busy_b;

  polar_serial_encoder #(.n(2)) dut_a (.clk(clk), .rst(rst), .bus(a), .busy(busy_a));
  polar_serial_encoder #(.n(3)) dut_b (.clk(clk), .rst(rst), .bus(b), .busy(busy_b));

`ifdef POLAR_FROZEN_FORCE_EN
  polar_serial_encoder_if #(.n(2)) c();
  logic busy_c;
  polar_serial_encoder #(.n(2), .FROZEN_MASK(4'b0011)) dut_c (.clk(clk), .rst(rst), .bus(c), .busy(busy_c));
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference: x[j] is the XOR of u_i over every i whose bits cover j.
  function automatic logic [7:0] golden(input logic [7:0] u, input int nn);
    logic [7:0] x;
    x = '0;
    for (int j = 0; j < (1 << nn); j++)
      for (int i = 0; i < (1 << nn); i++)
        if (((j & ~i) == 0) && u[i]) x[j] = ~x[j];
    return x;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic bv, output bit ok);
    int w;
    w = 0;
    a.u_valid = 1'b1;
    a.u_bit   = bv;
    while (!a.u_ready && w < 50) begin
      tick();
      w++;
    end
    ok = a.u_ready;
    tick();
    a.u_valid = 1'b0;
    a.u_bit   = 1'b0;
  endtask

  task automatic send_a(input logic [3:0] u, input bit gaps, output bit ok);
    bit o;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      push_a(u[i], o);
      ok &= o;
    end
  endtask

  task automatic take_a(output bit ok, output logic [3:0] xv);
    int w;
    w = 0;
    while (!a.x_valid && w < 50) begin
      tick();
      w++;
    end
    ok = a.x_valid;
    xv = a.x;
    a.x_ready = 1'b1;
    tick();
    a.x_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a.u_valid = 1'b0; a.u_bit = 1'b0; a.x_ready = 1'b0;
    b.u_valid = 1'b0; b.u_bit = 1'b0; b.x_ready = 1'b0;
`ifdef POLAR_FROZEN_FORCE_EN
    c.u_valid = 1'b0; c.u_bit = 1'b0; c.x_ready = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    vectors++; if (a.u_ready !== 1'b1) begin miscompares++; $display("FAIL reset_u_ready got=%b want=1", a.u_ready); end
    vectors++; if (a.x_valid !== 1'b0) begin miscompares++; $display("FAIL reset_x_valid got=%b want=0", a.x_valid); end
    vectors++; if (a.x !== 4'b0000) begin miscompares++; $display("FAIL reset_x got=%b want=0000", a.x); end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    vectors++; if (b.u_ready !== 1'b1 || b.x_valid !== 1'b0) begin miscompares++; $display("FAIL reset_n3 got u_ready=%b x_valid=%b want 1/0", b.u_ready, b.x_valid); end
  endtask

  task automatic test_rows;
    logic [3:0] pats [4];
    logic [3:0] xv, exp;
    bit ok;
    pats[0] = 4'b0001; pats[1] = 4'b1000; pats[2] = 4'b0010; pats[3] = 4'b0100;
    for (int p = 0; p < 4; p++) begin
      exp = golden({4'b0, pats[p]}, 2) ;
      send_a(pats[p], 1'b0, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rows_push pat=%b u_ready never high", pats[p]); end
      take_a(ok, xv);
      vectors++; if (!ok || xv !== exp) begin miscompares++; $display("FAIL rows_x u=%b got=%b valid=%b want=%b", pats[p], xv, ok, exp); end
    end
  endtask

  task automatic test_all_ones;
    logic [3:0] xv;
    bit ok;
    for (int i = 0; i < 3; i++) push_a(1'b1, ok);
    vectors++; if (a.x_valid !== 1'b0) begin miscompares++; $display("FAIL ones_early_valid got=%b want=0", a.x_valid); end
    push_a(1'b1, ok);
    vectors++; if (a.x_valid !== 1'b1) begin miscompares++; $display("FAIL ones_latency got x_valid=%b want=1", a.x_valid); end
    vectors++; if (a.x !== golden(8'h0f, 2)) begin miscompares++; $display("FAIL ones_x got=%b want=%b", a.x, golden(8'h0f, 2)); end
    vectors++; if (busy_a !== 1'b1 || a.u_ready !== 1'b0) begin miscompares++; $display("FAIL ones_out got busy=%b u_ready=%b want 1/0", busy_a, a.u_ready); end
    take_a(ok, xv);
    vectors++; if (a.u_ready !== 1'b1 || busy_a !== 1'b0) begin miscompares++; $display("FAIL ones_after_take got u_ready=%b busy=%b want 1/0", a.u_ready, busy_a); end
  endtask

  task automatic test_backpressure;
    logic [3:0] u, exp, xv;
    bit ok;
    u = 4'($urandom);
    exp = golden({4'b0, u}, 2);
    send_a(u, 1'b0, ok);
    for (int k = 0; k < 5; k++) begin
      a.u_valid = 1'($urandom);
      a.u_bit   = 1'($urandom);
      tick();
      vectors++;
      if (a.x_valid !== 1'b1 || a.u_ready !== 1'b0 || a.x !== exp) begin
        miscompares++;
        $display("FAIL bp_hold cyc=%0d got x_valid=%b u_ready=%b x=%b want 1/0/%b", k, a.x_valid, a.u_ready, a.x, exp);
      end
    end
    a.u_valid = 1'b0;
    take_a(ok, xv);
    vectors++; if (!ok || xv !== exp) begin miscompares++; $display("FAIL bp_x got=%b want=%b", xv, exp); end
    u = 4'($urandom);
    exp = golden({4'b0, u}, 2);
    send_a(u, 1'b0, ok);
    take_a(ok, xv);
    vectors++; if (!ok || xv !== exp) begin miscompares++; $display("FAIL bp_next u=%b got=%b want=%b", u, xv, exp); end
  endtask

  task automatic test_bubbles_and_reset;
    logic [3:0] u, exp, xv;
    bit ok;
    for (int f = 0; f < 4; f++) begin
      u = 4'($urandom);
      exp = golden({4'b0, u}, 2);
      send_a(u, 1'b1, ok);
      take_a(ok, xv);
      vectors++; if (!ok || xv !== exp) begin miscompares++; $display("FAIL bubble_x u=%b got=%b want=%b", u, xv, exp); end
    end
    push_a(1'b1, ok);
    push_a(1'b1, ok);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (a.u_ready !== 1'b1 || a.x_valid !== 1'b0 || busy_a !== 1'b0) begin
      miscompares++; $display("FAIL midreset got u_ready=%b x_valid=%b busy=%b want 1/0/0", a.u_ready, a.x_valid, busy_a);
    end
    send_a(4'b1000, 1'b0, ok);
    take_a(ok, xv);
    vectors++; if (!ok || xv !== 4'b1111) begin miscompares++; $display("FAIL after_reset_x got=%b want=1111", xv); end
  endtask

`ifdef POLAR_FROZEN_FORCE_EN
  task automatic test_frozen;
    logic [3:0] exp;
    exp = golden(8'h0f & ~8'h03, 2);
    c.u_valid = 1'b1;
    c.u_bit   = 1'b1;
    repeat (4) tick();
    c.u_valid = 1'b0;
    vectors++; if (c.x_valid !== 1'b1 || c.x !== exp) begin miscompares++; $display("FAIL frozen_x got valid=%b x=%b want 1/%b", c.x_valid, c.x, exp); end
    c.x_ready = 1'b1;
    tick();
    c.x_ready = 1'b0;
  endtask
`endif

  task automatic test_random_n3;
    logic [7:0] cur;
    logic [7:0] exp_q [$];
    logic [7:0] exp;
    int cnt, frames, cycles;
    cnt = 0; frames = 0; cycles = 0; cur = '0;
    while (frames < 1000 && cycles < 60000) begin
      b.u_valid = ($urandom_range(0, 9) < 7);
      b.u_bit   = 1'($urandom);
      b.x_ready = ($urandom_range(0, 9) < 6);
      if (b.x_valid) begin
        vectors++; if (b.u_ready !== 1'b0) begin miscompares++; $display("FAIL rand_ready_in_out got=%b want=0", b.u_ready); end
      end
      if (b.u_valid && b.u_ready) begin
        cur[cnt] = b.u_bit;
        cnt++;
        if (cnt == 8) begin
          exp_q.push_back(golden(cur, 3));
          cnt = 0;
        end
      end
      if (b.x_valid && b.x_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        vectors++; if (b.x !== exp) begin miscompares++; $display("FAIL rand_x frame=%0d got=%b want=%b", frames, b.x, exp); end
        frames++;
      end
      tick();
      cycles++;
    end
    b.u_valid = 1'b0;
    b.x_ready = 1'b0;
    vectors++; if (frames < 1000) begin miscompares++; $display("FAIL rand_timeout frames=%0d want=1000", frames); end
  endtask

  initial begin
    test_reset();
    test_rows();
    test_all_ones();
    test_backpressure();
    test_bubbles_and_reset();
`ifdef POLAR_FROZEN_FORCE_EN
    test_frozen();
`endif
    test_random_n3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
